// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle ops, Booth multiply, non-restoring divide.
// Divider is compiled in only when ALU_MC_DIV_EN is defined.
module alu_mc #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic               clock,
  input  logic               clear,
  input  logic               start,
  input  logic [4:0]         opcode,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result,
  output logic               div_by_zero,
  output logic               illegal_op
);

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_SHR  = 5'b00101;
  localparam logic [4:0] OP_SHL  = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_AND  = 5'b01001;
  localparam logic [4:0] OP_OR   = 5'b01010;
  localparam logic [4:0] OP_ADDI = 5'b01011;
  localparam logic [4:0] OP_ANDI = 5'b01100;
  localparam logic [4:0] OP_ORI  = 5'b01101;
  localparam logic [4:0] OP_MUL  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_NEG  = 5'b10000;
  localparam logic [4:0] OP_NOT  = 5'b10001;

  localparam logic [SHW-1:0] LAST = SHW'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE, EXEC, MUL, DIV, FIX, DONE
  } state_t;

  state_t state, state_n;

  logic [WIDTH-1:0]   a_q, b_q;
  logic [4:0]         op_q;
  logic [SHW-1:0]     cnt;
  logic               prime;
  logic [2*WIDTH-1:0] res;
  logic               ill;

  logic [SHW-1:0]     sh;
  logic [2*WIDTH-1:0] rot_r, rot_l;
  logic [WIDTH-1:0]   lo, hi;
  logic               bad, dz0;

  // Booth state: {acc, mq, qb} shifted arithmetically each step
  logic [WIDTH:0]     acc, acc_sum, acc_n, m_ext;
  logic [WIDTH-1:0]   mq, mq_n;
  logic               qb, qb_n;

  logic is_mul, is_div;

  assign is_mul = (opcode == OP_MUL);
`ifdef ALU_MC_DIV_EN
  assign is_div = (opcode == OP_DIV) && (B != '0);
`else
  assign is_div = 1'b0;
`endif

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (start) begin
        if (is_mul)      state_n = MUL;
        else if (is_div) state_n = DIV;
        else             state_n = EXEC;
      end
      EXEC: state_n = DONE;
      MUL:  if (prime && cnt == LAST) state_n = DONE;
`ifdef ALU_MC_DIV_EN
      DIV:  if (prime && cnt == LAST) state_n = FIX;
      FIX:  state_n = DONE;
`endif
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign sh    = b_q[SHW-1:0];
  assign rot_r = {a_q, a_q} >> sh;
  assign rot_l = {a_q, a_q} << sh;

  always_comb begin
    lo  = '0;
    hi  = '0;
    bad = 1'b0;
    dz0 = 1'b0;
    case (op_q)
      OP_LD, OP_LDI, OP_ST,
      OP_ADD, OP_ADDI: lo = a_q + b_q;
      OP_SUB:          lo = a_q - b_q;
      OP_SHR:          lo = a_q >> sh;
      OP_SHL:          lo = a_q << sh;
      OP_ROR:          lo = rot_r[WIDTH-1:0];
      OP_ROL:          lo = rot_l[2*WIDTH-1:WIDTH];
      OP_AND, OP_ANDI: lo = a_q & b_q;
      OP_OR, OP_ORI:   lo = a_q | b_q;
      OP_NEG:          lo = -b_q;
      OP_NOT:          lo = ~b_q;
`ifdef ALU_MC_DIV_EN
      // only reaches EXEC when the divisor is zero
      OP_DIV: begin
        lo  = '1;
        hi  = a_q;
        dz0 = 1'b1;
      end
`endif
      default:         bad = 1'b1;
    endcase
  end

  assign m_ext = {a_q[WIDTH-1], a_q};

  always_comb begin
    unique case ({mq[0], qb})
      2'b01:   acc_sum = acc + m_ext;
      2'b10:   acc_sum = acc - m_ext;
      default: acc_sum = acc;
    endcase
    acc_n = {acc_sum[WIDTH], acc_sum[WIDTH:1]};
    mq_n  = {acc_sum[0], mq[WIDTH-1:1]};
    qb_n  = mq[0];
  end

`ifdef ALU_MC_DIV_EN
  logic [WIDTH+1:0] rem, rem_sh, rem_n, d_ext;
  logic [WIDTH-1:0] quo, quo_n, dvs, r_fix, q_out, r_out;
  logic             dz;

  assign d_ext  = {2'b00, dvs};
  assign rem_sh = {rem[WIDTH:0], quo[WIDTH-1]};
  assign rem_n  = rem[WIDTH+1] ? rem_sh + d_ext : rem_sh - d_ext;
  assign quo_n  = {quo[WIDTH-2:0], ~rem_n[WIDTH+1]};
  assign r_fix  = rem[WIDTH-1:0] + (rem[WIDTH+1] ? dvs : '0);
  assign q_out  = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) ? -quo : quo;
  assign r_out  = a_q[WIDTH-1] ? -r_fix : r_fix;

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      rem <= '0;
      quo <= '0;
      dvs <= '0;
      dz  <= 1'b0;
    end else begin
      if (state == IDLE && start) dz <= 1'b0;
      if (state == EXEC) dz <= dz0;
      if (state == DIV) begin
        if (!prime) begin
          rem <= '0;
          quo <= a_q[WIDTH-1] ? -a_q : a_q;
          dvs <= b_q[WIDTH-1] ? -b_q : b_q;
        end else begin
          rem <= rem_n;
          quo <= quo_n;
        end
      end
    end
  end

  assign div_by_zero = dz;
`else
  assign div_by_zero = 1'b0;
`endif

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state <= IDLE;
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= '0;
      cnt   <= '0;
      prime <= 1'b0;
      res   <= '0;
      ill   <= 1'b0;
      acc   <= '0;
      mq    <= '0;
      qb    <= 1'b0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: if (start) begin
          a_q   <= A;
          b_q   <= B;
          op_q  <= opcode;
          cnt   <= '0;
          prime <= 1'b0;
          ill   <= 1'b0;
        end
        EXEC: begin
          res <= {hi, lo};
          ill <= bad;
        end
        // first cycle in MUL/DIV loads the iteration registers
        MUL: if (!prime) begin
          prime <= 1'b1;
          acc   <= '0;
          mq    <= b_q;
          qb    <= 1'b0;
        end else begin
          acc <= acc_n;
          mq  <= mq_n;
          qb  <= qb_n;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) res <= {acc_n[WIDTH-1:0], mq_n};
        end
`ifdef ALU_MC_DIV_EN
        DIV: if (!prime) prime <= 1'b1;
             else cnt <= cnt + 1'b1;
        FIX: res <= {r_out, q_out};
`endif
        default: ;
      endcase
    end
  end

  assign busy       = (state == EXEC) || (state == MUL) ||
                      (state == DIV) || (state == FIX);
  assign done       = (state == DONE);
  assign result     = res;
  assign illegal_op = ill;

endmodule

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc: latency, busy window, results and flags.
// Honours ALU_MC_DIV_EN for the divide expectations.
module tb_alu_mc;
  localparam int W = 32;

  logic          clock = 1'b0;
  logic          clear;
  logic          start;
  logic [4:0]    opcode;
  logic [W-1:0]  A, B;
  logic          busy, done, div_by_zero, illegal_op;
  logic [2*W-1:0] result;

  int errs = 0;
  int checks = 0;
  logic [63:0] prev = '0;

  always #5 clock = ~clock;

  alu_mc #(.WIDTH(W)) dut (
    .clock(clock), .clear(clear), .start(start), .opcode(opcode),
    .A(A), .B(B), .busy(busy), .done(done), .result(result),
    .div_by_zero(div_by_zero), .illegal_op(illegal_op)
  );

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [4:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp, input int lat,
                        input logic exp_dz, input logic exp_ill,
                        input int inj);
    int n;
    int bc;
    opcode = op;
    A = a;
    B = b;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    A = ~a;
    B = ~b;
    opcode = 5'h1f;
    n = 1;
    bc = 0;
    check({tag, ":flagclr"}, {62'd0, div_by_zero, illegal_op}, 64'd0);
    check({tag, ":hold"}, result, prev);
    while (!done && n < 200) begin
      if (busy) bc++;
      if (n == inj) begin
        start = 1'b1;
        opcode = 5'b00011;
      end else begin
        start = 1'b0;
      end
      @(posedge clock); #1;
      n++;
    end
    start = 1'b0;
    check({tag, ":lat"}, 64'(n), 64'(lat));
    check({tag, ":busy"}, 64'(bc), 64'(lat - 1));
    check({tag, ":res"}, result, exp);
    check({tag, ":dz"}, {63'd0, div_by_zero}, {63'd0, exp_dz});
    check({tag, ":ill"}, {63'd0, illegal_op}, {63'd0, exp_ill});
    check({tag, ":busy@done"}, {63'd0, busy}, 64'd0);
    @(posedge clock); #1;
    check({tag, ":pulse"}, {63'd0, done}, 64'd0);
    check({tag, ":held"}, result, exp);
    prev = exp;
  endtask

  initial begin
    int seen;
    clear = 1'b1;
    start = 1'b0;
    opcode = '0;
    A = '0;
    B = '0;
    #12;
    check("rst:busy", {63'd0, busy}, 64'd0);
    check("rst:done", {63'd0, done}, 64'd0);
    check("rst:res", result, 64'd0);
    check("rst:dz", {63'd0, div_by_zero}, 64'd0);
    check("rst:ill", {63'd0, illegal_op}, 64'd0);
    @(negedge clock);
    clear = 1'b0;
    @(posedge clock); #1;

    run_op("add", 5'b00011, 32'h7FFFFFFF, 32'h1,
           64'h0000_0000_8000_0000, 2, 0, 0, 0);
    run_op("sub", 5'b00100, 32'd3, 32'd5,
           64'h0000_0000_FFFF_FFFE, 2, 0, 0, 0);
    run_op("ldi", 5'b00001, 32'd10, 32'd20, 64'd30, 2, 0, 0, 0);
    run_op("shr", 5'b00101, 32'h80000000, 32'd31, 64'd1, 2, 0, 0, 0);
    run_op("shl", 5'b00110, 32'h1, 32'h24, 64'h10, 2, 0, 0, 0);
    run_op("ror", 5'b00111, 32'h1, 32'd33,
           64'h0000_0000_8000_0000, 2, 0, 0, 0);
    run_op("rol", 5'b01000, 32'h80000001, 32'd4, 64'h18, 2, 0, 0, 0);
    run_op("and", 5'b01001, 32'hF0F0F0F0, 32'hFF00FF00,
           64'h0000_0000_F000_F000, 2, 0, 0, 0);
    run_op("ori", 5'b01101, 32'h0F0F0000, 32'h000000F0,
           64'h0000_0000_0F0F_00F0, 2, 0, 0, 0);
    run_op("neg", 5'b10000, 32'd5, 32'd1,
           64'h0000_0000_FFFF_FFFF, 2, 0, 0, 0);
    run_op("not", 5'b10001, 32'd5, 32'h0000FFFF,
           64'h0000_0000_FFFF_0000, 2, 0, 0, 0);
    run_op("ill", 5'b11111, 32'd9, 32'd9, 64'd0, 2, 0, 1, 0);

    run_op("mul1", 5'b01110, 32'hFFFFFFFD, 32'd7,
           64'hFFFF_FFFF_FFFF_FFEB, 34, 0, 0, 5);
    run_op("mul2", 5'b01110, 32'h80000000, 32'h80000000,
           64'h4000_0000_0000_0000, 34, 0, 0, 0);
    run_op("mul3", 5'b01110, 32'h7FFFFFFF, 32'h7FFFFFFF,
           64'h3FFF_FFFF_0000_0001, 34, 0, 0, 0);

`ifdef ALU_MC_DIV_EN
    run_op("div1", 5'b01111, 32'hFFFFFFEF, 32'd5,
           64'hFFFF_FFFE_FFFF_FFFD, 35, 0, 0, 0);
    run_op("div2", 5'b01111, 32'd7, 32'hFFFFFFFE,
           64'h0000_0001_FFFF_FFFD, 35, 0, 0, 0);
    run_op("div3", 5'b01111, 32'h80000000, 32'hFFFFFFFF,
           64'h0000_0000_8000_0000, 35, 0, 0, 0);
    run_op("div0", 5'b01111, 32'd5, 32'd0,
           64'h0000_0005_FFFF_FFFF, 2, 1, 0, 0);
`else
    run_op("div1", 5'b01111, 32'hFFFFFFEF, 32'd5, 64'd0, 2, 0, 1, 0);
    run_op("div0", 5'b01111, 32'd5, 32'd0, 64'd0, 2, 0, 1, 0);
`endif

    run_op("add2", 5'b00011, 32'd1, 32'd1, 64'd2, 2, 0, 0, 0);

    opcode = 5'b01110;
    A = 32'd3;
    B = 32'd3;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    for (int i = 1; i < 10; i++) begin
      @(posedge clock); #1;
    end
    clear = 1'b1;
    #1;
    check("clr:busy", {63'd0, busy}, 64'd0);
    check("clr:done", {63'd0, done}, 64'd0);
    check("clr:res", result, 64'd0);
    @(negedge clock);
    clear = 1'b0;
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clock); #1;
      if (done) seen++;
    end
    check("clr:nodone", 64'(seen), 64'd0);
    prev = '0;
    run_op("add22", 5'b00011, 32'd2, 32'd2, 64'd4, 2, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
